// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for pipeline sequencing: debug counter select codes
// and the default reset PC, also used by the debug unit.
package pipe_ctrl_pkg;

  localparam logic [31:0] PC_INIT_DEF = 32'h0000_3000;

  localparam logic [1:0] DBG_CYCLE  = 2'd0;
  localparam logic [1:0] DBG_STALL  = 2'd1;
  localparam logic [1:0] DBG_FLUSH  = 2'd2;
  localparam logic [1:0] DBG_RETIRE = 2'd3;

endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// Wrapping performance counter; a synchronous clear wins over increment.
module perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: PC register, per-stage valid bits, segment-register
// hold/bubble controls and the four debug-visible performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_INIT = PC_INIT_DEF,
  parameter int          CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      npc,
  input  logic             stall_if,
  input  logic             stall_id,
  input  logic             stall_ex,
  input  logic             flush_id,
  input  logic             flush_ex,
  input  logic             flush_mem,
  input  logic             cnt_clr,
  input  logic [1:0]       dbg_sel,
  output logic [31:0]      pc_if,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic             en_id,
  output logic             en_ex,
  output logic             bub_id,
  output logic             bub_ex,
  output logic             bub_mem,
  output logic             retire,
  output logic [CNT_W-1:0] dbg_data
);

  logic [31:0] pc_q, pc_d;
  logic        valid_id_q, valid_id_d;
  logic        valid_ex_q, valid_ex_d;
  logic        valid_mem_q, valid_mem_d;
  logic        valid_wb_q, valid_wb_d;
  logic        kill_id, kill_ex, kill_mem;
  logic [CNT_W-1:0] cnt_cycle, cnt_stall, cnt_flush, cnt_retire;

  // Stall beats flush so a branch waiting on a hazard is not lost; it re-flushes later.
  assign kill_id  = flush_id & ~stall_id;
  assign kill_ex  = flush_ex & ~stall_ex;
  assign kill_mem = flush_mem;

  always_comb begin
    pc_d        = stall_if ? pc_q : npc;
    valid_id_d  = kill_id ? 1'b0 : (stall_id ? valid_id_q : 1'b1);
    valid_ex_d  = kill_ex ? 1'b0 : (stall_ex ? valid_ex_q : valid_id_q);
    valid_mem_d = kill_mem ? 1'b0 : valid_ex_q;
    valid_wb_d  = valid_mem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= PC_INIT;
      valid_id_q  <= 1'b0;
      valid_ex_q  <= 1'b0;
      valid_mem_q <= 1'b0;
      valid_wb_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      valid_id_q  <= valid_id_d;
      valid_ex_q  <= valid_ex_d;
      valid_mem_q <= valid_mem_d;
      valid_wb_q  <= valid_wb_d;
    end
  end

  assign pc_if     = pc_q;
  assign valid_id  = valid_id_q;
  assign valid_ex  = valid_ex_q;
  assign valid_mem = valid_mem_q;
  assign valid_wb  = valid_wb_q;
  assign retire    = valid_wb_q;
  assign en_id     = ~stall_id;
  assign en_ex     = ~stall_ex;
  assign bub_id    = kill_id;
  assign bub_ex    = kill_ex;
  assign bub_mem   = kill_mem;

  perf_cnt #(.CNT_W(CNT_W)) u_cnt_cycle (
    .clk(clk), .rst(rst), .inc_i(1'b1),       .clr_i(cnt_clr), .cnt_o(cnt_cycle));
  perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk(clk), .rst(rst), .inc_i(stall_if),   .clr_i(cnt_clr), .cnt_o(cnt_stall));
  perf_cnt #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .rst(rst), .inc_i(kill_ex),    .clr_i(cnt_clr), .cnt_o(cnt_flush));
  perf_cnt #(.CNT_W(CNT_W)) u_cnt_retire (
    .clk(clk), .rst(rst), .inc_i(valid_wb_q), .clr_i(cnt_clr), .cnt_o(cnt_retire));

  always_comb begin
    dbg_data = cnt_retire;
    case (dbg_sel)
      DBG_CYCLE: dbg_data = cnt_cycle;
      DBG_STALL: dbg_data = cnt_stall;
      DBG_FLUSH: dbg_data = cnt_flush;
      default:   dbg_data = cnt_retire;
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, free run, load-use, branch,
// stall-vs-flush priority, counter wrap/clear and debug select mapping.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        stall_if, stall_id, stall_ex;
  logic        flush_id, flush_ex, flush_mem;
  logic        cnt_clr;
  logic [1:0]  dbg_sel;
  logic [31:0] pc_if;
  logic        valid_id, valid_ex, valid_mem, valid_wb;
  logic        en_id, en_ex, bub_id, bub_ex, bub_mem, retire;
  logic [31:0] dbg_data;

  logic        br_en;
  logic [31:0] br_tgt;
  int          n_pass  = 0;
  int          n_total = 0;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .npc(npc),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .cnt_clr(cnt_clr), .dbg_sel(dbg_sel),
    .pc_if(pc_if),
    .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem), .valid_wb(valid_wb),
    .en_id(en_id), .en_ex(en_ex),
    .bub_id(bub_id), .bub_ex(bub_ex), .bub_mem(bub_mem),
    .retire(retire), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Sequential fetch unless a branch target is being presented.
  assign npc = br_en ? br_tgt : pc_if + 32'd4;

  always @(negedge clk)
    if (!rst && stall_ex && !stall_id)
      $display("NOTE: inconsistent request stall_ex without stall_id at %0t", $time);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    dbg_sel = sel;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic chk_valid(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, valid_id, valid_ex, valid_mem, valid_wb}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_if = 0; stall_id = 0; stall_ex = 0;
    flush_id = 0; flush_ex = 0; flush_mem = 0;
    cnt_clr = 0; br_en = 0; br_tgt = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    dbg_sel = 2'd0;
    idle_inputs();
    #2;
    // reset state
    chk("rst_pc", pc_if, 32'h3000);
    chk_valid("rst_valid", 4'b0000);
    chk("rst_comb", {26'd0, en_id, en_ex, bub_id, bub_ex, bub_mem, retire}, 32'b110000);
    chk_cnt("rst_cycle", 2'd0, 32'd0);
    chk_cnt("rst_retire", 2'd3, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // free run, 10 edges
    repeat (10) tick();
    chk("run_pc", pc_if, 32'h3028);
    chk_valid("run_valid", 4'b1111);
    chk_cnt("run_cycle", 2'd0, 32'd10);
    chk_cnt("run_retire", 2'd3, 32'd6);
    chk_cnt("run_stall", 2'd1, 32'd0);
    chk_cnt("run_flush", 2'd2, 32'd0);

    // asynchronous reset mid-run
    repeat (6) tick();
    chk("pre_rst_pc", pc_if, 32'h3040);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", pc_if, 32'h3000);
    chk_valid("mid_rst_valid", 4'b0000);
    chk_cnt("mid_rst_cycle", 2'd0, 32'd0);
    chk_cnt("mid_rst_retire", 2'd3, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // load-use stall at pc 3010
    repeat (4) tick();
    chk("lu_pre_pc", pc_if, 32'h3010);
    stall_if = 1; stall_id = 1; stall_ex = 1; flush_mem = 1;
    #1;
    chk("lu_comb", {27'd0, en_id, en_ex, bub_id, bub_ex, bub_mem}, 32'b00001);
    tick();
    idle_inputs();
    chk("lu_pc_hold", pc_if, 32'h3010);
    chk_valid("lu_valid_e5", 4'b1101);
    chk_cnt("lu_stall", 2'd1, 32'd1);
    tick();
    chk_valid("lu_valid_e6", 4'b1110);
    chk("lu_retire_gap", {31'd0, retire}, 32'd0);
    tick();
    chk("lu_pc_e7", pc_if, 32'h3018);
    chk_cnt("lu_retire_cnt", 2'd3, 32'd2);

    // taken branch to 3100
    flush_id = 1; flush_ex = 1; br_en = 1; br_tgt = 32'h3100;
    #1;
    chk("br_comb", {27'd0, en_id, en_ex, bub_id, bub_ex, bub_mem}, 32'b11110);
    tick();
    idle_inputs();
    chk("br_pc", pc_if, 32'h3100);
    chk_valid("br_valid_e8", 4'b0011);
    chk_cnt("br_flush", 2'd2, 32'd1);
    tick();
    chk_valid("br_valid_e9", 4'b1001);
    tick();
    chk_valid("br_valid_e10", 4'b1100);
    tick();
    chk_valid("br_valid_e11", 4'b1110);
    tick();
    chk_valid("br_valid_e12", 4'b1111);
    chk("br_pc_e12", pc_if, 32'h3110);
    chk_cnt("br_retire_cnt", 2'd3, 32'd5);

    // stall and flush in the same cycle: stall wins
    stall_if = 1; stall_id = 1; stall_ex = 1; flush_ex = 1; flush_mem = 1;
    #1;
    chk("sf_comb", {27'd0, en_id, en_ex, bub_id, bub_ex, bub_mem}, 32'b00001);
    tick();
    idle_inputs();
    chk_valid("sf_valid_held", 4'b1101);
    chk_cnt("sf_flush_same", 2'd2, 32'd1);
    chk_cnt("sf_stall", 2'd1, 32'd2);
    flush_id = 1; flush_ex = 1; br_en = 1; br_tgt = 32'h3200;
    tick();
    idle_inputs();
    chk("sf_pc", pc_if, 32'h3200);
    chk_valid("sf_valid_flushed", 4'b0010);
    chk_cnt("sf_flush_next", 2'd2, 32'd2);

    // stall counter wrap
    @(negedge clk);
    force u_dut.u_cnt_stall.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_cnt_stall.cnt_q;
    chk_cnt("wrap_preload", 2'd1, 32'hFFFF_FFFF);
    stall_if = 1;
    tick();
    chk_cnt("wrap_zero", 2'd1, 32'd0);

    // clear wins over increment
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    chk_cnt("clr_cycle", 2'd0, 32'd0);
    chk_cnt("clr_stall", 2'd1, 32'd0);
    chk_cnt("clr_flush", 2'd2, 32'd0);
    chk_cnt("clr_retire", 2'd3, 32'd0);

    // distinct values on every select code
    tick();
    tick();
    stall_if = 0; flush_ex = 1;
    tick();
    flush_ex = 0; stall_if = 1;
    tick();
    idle_inputs();
    chk_cnt("sel_cycle", 2'd0, 32'd4);
    chk_cnt("sel_stall", 2'd1, 32'd3);
    chk_cnt("sel_flush", 2'd2, 32'd1);
    chk_cnt("sel_retire", 2'd3, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish by 100000ns");
    $fatal(1, "timeout");
  end

endmodule
